multiport_memory_controller: RTL

Parametrised successor to the single-client memory controller: fronts one synchronous single-port RAM with `NUM_PORTS` independent valid/ready request channels and a round-robin arbiter. Supports reads, writes, per-port responses and a boot-time RAM clear. Sits between the Lisp evaluator, GC and I/O loader and the cons-cell store, and is the only path to heap memory.

---
 rtl/multiport_memory_controller_pkg.sv | 21 ++
 rtl/multiport_memory_controller_ram.sv | 33 +++
 rtl/multiport_memory_controller.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/multiport_memory_controller_pkg.sv
// Shared types for the heap memory controller.
// Optional: MULTIPORT_MEMCTRL_BOUNDS_CHECK_EN enables the rsp_err flag.
package lisp;

    localparam int data_width    = 32;
    localparam int MEM_MAX_PORTS = 8;
    localparam int MEM_MAX_ADDR  = 32;
    localparam int MEM_MAX_DATA  = 64;

    typedef enum logic [0:0] {
        BOOT = 1'b0,
        IDLE = 1'b1
    } mem_state_t;

    typedef struct packed {
        logic                    write;
        logic [MEM_MAX_ADDR-1:0] addr;
        logic [MEM_MAX_DATA-1:0] wdata;
    } mem_req_t;

endpackage

// File: rtl/multiport_memory_controller_ram.sv
// Single-port synchronous RAM backing the cons-cell store.
// Write-first: a write returns its own data on rdata.
module lisp_ram #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 2 ** ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] ram [DEPTH];

    always_ff @(posedge clk) begin
        if (en && we) begin
            ram[addr] <= wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata <= '0;
        end else if (en) begin
            rdata <= we ? wdata : ram[addr];
        end
    end

endmodule

// File: rtl/multiport_memory_controller.sv
// Round-robin multi-client front end to the heap RAM, with boot clear.
// Optional: MULTIPORT_MEMCTRL_BOUNDS_CHECK_EN reports out-of-range accesses on rsp_err.
module multiport_memory_controller
    import lisp::*;
#(
    parameter int ADDR_WIDTH  = 10,
    parameter int DATA_WIDTH  = lisp::data_width,
    parameter int DEPTH       = 2 ** ADDR_WIDTH,
    parameter int NUM_PORTS   = 2,
    parameter bit BYPASS_BOOT = 1'b0
) (
    input  logic                            clk,
    input  logic                            rst,
    output logic                            boot_done,
    input  logic [NUM_PORTS-1:0]            req_valid,
    output logic [NUM_PORTS-1:0]            req_ready,
    input  logic [NUM_PORTS-1:0]            req_write,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0] req_wdata,
    output logic [NUM_PORTS-1:0]            rsp_valid,
    output logic [DATA_WIDTH-1:0]           rsp_rdata,
    output logic [NUM_PORTS-1:0]            rsp_err
);

    localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    mem_state_t            state;
    logic [ADDR_WIDTH-1:0] cnt;
    logic [PW-1:0]         ptr;
    logic [PW-1:0]         gidx;
    logic                  found;
    logic                  granted;
    logic [NUM_PORTS-1:0]  grant;
    mem_req_t              req;
    logic                  in_range;
    logic                  oob_q;

    logic                  ram_en;
    logic                  ram_we;
    logic [ADDR_WIDTH-1:0] ram_addr;
    logic [DATA_WIDTH-1:0] ram_wdata;
    logic [DATA_WIDTH-1:0] ram_rdata;

    // Scan from ptr, wrapping, and take the first requester.
    always_comb begin
        int idx;
        idx   = 0;
        found = 1'b0;
        gidx  = '0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            idx = int'(ptr) + k;
            if (idx >= NUM_PORTS) begin
                idx = idx - NUM_PORTS;
            end
            if (!found && req_valid[idx]) begin
                found = 1'b1;
                gidx  = PW'(idx);
            end
        end
    end

    assign granted = found && (state == IDLE);

    always_comb begin
        grant = '0;
        if (granted) begin
            grant[gidx] = 1'b1;
        end
    end

    assign req_ready = grant;
    assign boot_done = (state == IDLE);

    always_comb begin
        req = '0;
        req.write = req_write[gidx];
        req.addr[ADDR_WIDTH-1:0] =
            req_addr[int'(gidx)*ADDR_WIDTH +: ADDR_WIDTH];
        req.wdata[DATA_WIDTH-1:0] =
            req_wdata[int'(gidx)*DATA_WIDTH +: DATA_WIDTH];
    end

    assign in_range = req.addr < MEM_MAX_ADDR'(DEPTH);

    logic unused_req;
    assign unused_req = ^req.wdata;

    // Boot owns the RAM; afterwards only in-range grants touch it.
    always_comb begin
        if (state == BOOT) begin
            ram_en    = 1'b1;
            ram_we    = 1'b1;
            ram_addr  = cnt;
            ram_wdata = '0;
        end else begin
            ram_en    = granted && in_range;
            ram_we    = req.write;
            ram_addr  = req.addr[ADDR_WIDTH-1:0];
            ram_wdata = req.wdata[DATA_WIDTH-1:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= BYPASS_BOOT ? IDLE : BOOT;
            cnt       <= '0;
            ptr       <= '0;
            rsp_valid <= '0;
            oob_q     <= 1'b0;
        end else begin
            rsp_valid <= grant;
            if (state == BOOT) begin
                cnt <= cnt + 1'b1;
                if (cnt == ADDR_WIDTH'(DEPTH - 1)) begin
                    state <= IDLE;
                end
            end
            if (granted) begin
                oob_q <= !in_range;
                if (gidx == PW'(NUM_PORTS - 1)) begin
                    ptr <= '0;
                end else begin
                    ptr <= gidx + PW'(1);
                end
            end
        end
    end

    assign rsp_rdata = oob_q ? '0 : ram_rdata;

`ifdef MULTIPORT_MEMCTRL_BOUNDS_CHECK_EN
    assign rsp_err = oob_q ? rsp_valid : '0;
`else
    assign rsp_err = '0;
`endif

    lisp_ram #(
        .ADDR_WIDTH(ADDR_WIDTH),
        .DATA_WIDTH(DATA_WIDTH),
        .DEPTH     (DEPTH)
    ) ram (
        .clk  (clk),
        .rst  (rst),
        .en   (ram_en),
        .we   (ram_we),
        .addr (ram_addr),
        .wdata(ram_wdata),
        .rdata(ram_rdata)
    );

endmodule
